// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4
   import arb_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [NUM_REQ-1:0] y
);

   // NOTE: default every combinational output first so no path infers a latch.
   always_comb begin
      y = '0;
      if (en) y[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and a mandatory
// idle cycle between grants; all outputs come from flops.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter  int MAX_HOLD = 15,
   localparam int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               timeout
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   hold_q, hold_d;

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [IDX_W-1:0]     pick_off;
   logic [IDX_W-1:0]     winner;
   logic                 at_limit;
   logic                 owner_drop;

   // Rotate so the pointer's requester sits at bit 0, pick the lowest set
   // bit, then add the pointer back to recover the absolute index.
   always_comb begin
      req_dbl  = {req, req} >> ptr_q;
      req_rot  = req_dbl[NUM_REQ-1:0];
      pick_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) pick_off = IDX_W'(i);
      end
      winner = ptr_q + pick_off;
   end

   always_comb begin
      at_limit   = (hold_q == CNT_W'(MAX_HOLD - 1));
      owner_drop = !req[idx_q];

      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               idx_d   = winner;
               valid_d = 1'b1;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (done || owner_drop || at_limit) begin
               state_d   = IDLE;
               valid_d   = 1'b0;
               ptr_d     = idx_q + 1'b1;
               hold_d    = '0;
               // A limit release that coincides with done or a req drop is normal.
               timeout_d = at_limit && !done && !owner_drop;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
      end
   end

   dec2to4 u_dec (
      .en  (valid_q),
      .idx (idx_q),
      .y   (grant)
   );

   assign grant_idx   = idx_q;
   assign grant_valid = valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with MAX_HOLD=3, one with
// MAX_HOLD=2 for the limit-coincidence cases.
module tb_rr_arbiter4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_a, req_b;
   logic       done_a, done_b;
   logic [3:0] grant_a, grant_b;
   logic [1:0] idx_a, idx_b;
   logic       valid_a, valid_b;
   logic       to_a, to_b;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   rr_arbiter4 #(.MAX_HOLD(3)) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .req         (req_a),
      .done        (done_a),
      .grant       (grant_a),
      .grant_idx   (idx_a),
      .grant_valid (valid_a),
      .timeout     (to_a)
   );

   rr_arbiter4 #(.MAX_HOLD(2)) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .req         (req_b),
      .done        (done_b),
      .grant       (grant_b),
      .grant_idx   (idx_b),
      .grant_valid (valid_b),
      .timeout     (to_b)
   );

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      assert_cnt++;
      assert (observed === expected) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] idx,
                          input logic to);
      check({tag, ".grant"}, {4'h0, grant_a}, {4'h0, g});
      check({tag, ".idx"},   {6'h0, idx_a},   {6'h0, idx});
      check({tag, ".valid"}, {7'h0, valid_a}, {7'h0, |g});
      check({tag, ".tmo"},   {7'h0, to_a},    {7'h0, to});
   endtask

   task automatic check_b(input string tag, input logic [3:0] g, input logic to);
      check({tag, ".grant"}, {4'h0, grant_b}, {4'h0, g});
      check({tag, ".valid"}, {7'h0, valid_b}, {7'h0, |g});
      check({tag, ".tmo"},   {7'h0, to_b},    {7'h0, to});
   endtask

   // Advance one rising edge and settle before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
      seq[3] = 4'b1000; seq[4] = 4'b0001;

      rst = 1'b1; req_a = '0; req_b = '0; done_a = 1'b0; done_b = 1'b0;
      step();
      step();
      check_a("reset", 4'b0000, 2'd0, 1'b0);
      check_b("reset_b", 4'b0000, 1'b0);
      rst = 1'b0;
      step();
      check_a("idle0", 4'b0000, 2'd0, 1'b0);
      step();
      check_a("idle1", 4'b0000, 2'd0, 1'b0);

      // Round robin with all requesters active, done on each 2nd grant cycle.
      req_a = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         check_a($sformatf("rr%0d.c1", i), seq[i], 2'(i % 4), 1'b0);
         step();
         check_a($sformatf("rr%0d.c2", i), seq[i], 2'(i % 4), 1'b0);
         done_a = 1'b1;
         step();
         done_a = 1'b0;
         check_a($sformatf("rr%0d.gap", i), 4'b0000, 2'(i % 4), 1'b0);
      end
      req_a = 4'b0000;
      step();
      check_a("rr.idle", 4'b0000, 2'd0, 1'b0);

      // Timeout with MAX_HOLD=3; pointer is 1 here.
      req_a = 4'b0100;
      step();
      check_a("to.c1", 4'b0100, 2'd2, 1'b0);
      step();
      check_a("to.c2", 4'b0100, 2'd2, 1'b0);
      step();
      check_a("to.c3", 4'b0100, 2'd2, 1'b0);
      step();
      check_a("to.pulse", 4'b0000, 2'd2, 1'b1);
      step();
      check_a("to.regrant", 4'b0100, 2'd2, 1'b0);
      req_a = 4'b0000;
      step();
      check_a("to.drop", 4'b0000, 2'd2, 1'b0);

      // Request drop: pointer is 3, owner 1 drops, next search starts at 2.
      req_a = 4'b0010;
      step();
      check_a("drop.grant", 4'b0010, 2'd1, 1'b0);
      req_a = 4'b0000;
      step();
      check_a("drop.rel", 4'b0000, 2'd1, 1'b0);
      req_a = 4'b0011;
      step();
      check_a("drop.next", 4'b0001, 2'd0, 1'b0);
      req_a = 4'b0000;
      step();
      check_a("drop.idle", 4'b0000, 2'd0, 1'b0);

      // Reset while granting: outputs clear, pointer back to 0, no timeout.
      req_a = 4'b1000;
      step();
      check_a("rstg.grant", 4'b1000, 2'd3, 1'b0);
      rst = 1'b1;
      step();
      check_a("rstg.clear", 4'b0000, 2'd0, 1'b0);
      check_b("rstg.clear_b", 4'b0000, 1'b0);
      rst = 1'b0;
      req_a = 4'b1001;
      step();
      check_a("rstg.ptr0", 4'b0001, 2'd0, 1'b0);
      req_a = 4'b0000;
      step();
      check_a("rstg.idle", 4'b0000, 2'd0, 1'b0);

      // MAX_HOLD=2: done on the limit cycle is a normal release.
      req_b = 4'b0001;
      step();
      check_b("lim.c1", 4'b0001, 1'b0);
      step();
      check_b("lim.c2", 4'b0001, 1'b0);
      done_b = 1'b1;
      step();
      done_b = 1'b0;
      check_b("lim.done_rel", 4'b0000, 1'b0);
      step();
      check_b("lim.regrant", 4'b0001, 1'b0);
      step();
      check_b("lim.c2b", 4'b0001, 1'b0);
      step();
      check_b("lim.timeout", 4'b0000, 1'b1);
      req_b = 4'b0000;
      step();
      check_b("lim.idle", 4'b0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with a bounded hold time that shares a single downstream resource (bus, port or datapath slot) among four clients. The 2-bit winner index is expanded to a one-hot grant vector by a 2-to-4 decoder sub-module. The arbiter grants exactly one requester at a time, holds the grant until release or timeout, then rotates priority past the last winner. It sits between the client request lines and the shared resource's select/enable inputs.

## Interface
- MAX_HOLD, 15, maximum consecutive cycles one grant may be held (legal range 1..255).
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter (derived; not overridden).

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  4  request lines; bit i is requester i; level-sensitive.
- done  input  1  single-cycle release pulse from the current owner.
- grant  output  4  one-hot grant; all zero when idle.
- grant_idx  output  2  index of the current owner; holds the last value when idle.
- grant_valid  output  1  high while any grant is active; equals |grant.
- timeout  output  1  one-cycle pulse when a grant is forcibly released at MAX_HOLD.

## Operation
- States: IDLE, GRANT. All outputs are registered.
- Priority pointer ptr (2 bits) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE: if req != 0, select the first set bit in search order. Next state is GRANT, grant_idx = winner, and hold_cnt = 0. If req == 0, stay in IDLE.
- GRANT: hold_cnt increments by 1 each cycle. Release is required when any of the following holds:
  - done = 1;
  - req[grant_idx] = 0;
  - hold_cnt == MAX_HOLD-1.
- On release: next state is IDLE, grant = 0, and ptr = grant_idx+1 (wraps 3 -> 0).
- timeout = 1 on the release cycle only when the counter limit caused the release and neither done nor the req drop did. If done or the req drop coincides with the limit, it is a normal release and timeout = 0.
- Requests from non-owners during GRANT are ignored. They do not pre-empt the owner.
- The decoder drives grant from grant_idx, gated by grant_valid. grant is never multi-hot.

## Timing
- Reset values: state IDLE, grant 4'b0000, grant_idx 2'b00, grant_valid 0, timeout 0, ptr 0, hold_cnt 0.
- Reset mid-GRANT: at the next edge all grant outputs are 0 and ptr returns to 0. No timeout pulse is generated.
- Grant latency: req sampled at edge N in IDLE produces grant valid after edge N, i.e. in cycle N+1.
- Release latency: done sampled at edge M produces grant = 0 in cycle M+1.
- Mandatory single IDLE cycle between grants. Back-to-back grants are therefore separated by one dead cycle. Maximum re-grant latency for a persistent requester is 4×(MAX_HOLD+1) cycles.
- Maximum grant length is exactly MAX_HOLD cycles. With MAX_HOLD = 1, every grant lasts one cycle.
- hold_cnt never exceeds MAX_HOLD-1. It does not wrap.

## Structure
- Shared package arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - NUM_REQ = 4 and IDX_W = 2 constants.
- Sub-module dec2to4: combinational 2-to-4 decoder with enable (inputs en and idx[1:0], output y[3:0]). It is instantiated once to produce grant.
- The pointer, the counter and the priority search live in rr_arbiter4. The search is a rotate, a fixed-priority pick and an un-rotate.

## Test plan
- Reset/idle: rst = 1 for 2 cycles, then req = 0 → grant = 0000, grant_valid = 0, grant_idx = 00, timeout = 0 on every cycle.
- Simultaneous requests with all req held at 1111 and done pulsed on each owner's 2nd grant cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle (0000) between grants.
- Timeout: MAX_HOLD = 3, req = 0100 held, no done → grant = 0100 for exactly 3 cycles, then timeout = 1 for one cycle with grant = 0000, then re-grant 0100.
- Request drop: grant on req 0010, then req[1] falls → grant = 0000 the next cycle, timeout = 0, and the next winner is searched from index 2 (req = 0011 → 0001).
- Coincident done at limit: MAX_HOLD = 2, done asserted on the 2nd grant cycle → release with timeout = 0.
- Reset mid-GRANT: grant = 1000 active, rst pulsed → grant = 0000 next cycle and ptr = 0; with req = 1001 the next grant is 0001.
